mem_port_arbiter: RTL and testbench

Arbiter that shares the single-port unified instruction/data memory between the multicycle MIPS core and a secondary DMA/loader master. It owns the memory address, write-data and write-enable muxes. When the DMA master holds the port, it freezes the core through `cpu_stall`. A burst limit with a guaranteed CPU slot prevents core starvation. The block sits between the core's memory pins and the memory; read data is broadcast to both masters.

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Memory-port bus bundle: core pins, DMA/loader pins and the shared single-port memory.
// slave = arbiter side, master = environment (core, DMA, memory) side.
interface mem_port_arbiter_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wr_data;
  logic        cpu_wr_ena;
  logic [31:0] cpu_rd_data;
  logic        cpu_stall;
  logic        dma_req;
  logic [31:0] dma_addr;
  logic [31:0] dma_wr_data;
  logic        dma_wr_ena;
  logic        dma_gnt;
  logic        dma_ack;
  logic [31:0] dma_rd_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data;

  modport slave (
    input  cpu_addr, cpu_wr_data, cpu_wr_ena,
    input  dma_req, dma_addr, dma_wr_data, dma_wr_ena,
    input  mem_rd_data,
    output cpu_rd_data, cpu_stall,
    output dma_gnt, dma_ack, dma_rd_data,
    output mem_addr, mem_wr_data, mem_wr_ena
  );

  modport master (
    output cpu_addr, cpu_wr_data, cpu_wr_ena,
    output dma_req, dma_addr, dma_wr_data, dma_wr_ena,
    output mem_rd_data,
    input  cpu_rd_data, cpu_stall,
    input  dma_gnt, dma_ack, dma_rd_data,
    input  mem_addr, mem_wr_data, mem_wr_ena
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the MIPS core and a DMA/loader, with a DMA burst limit and forced core slot.
// MEM_ARB_BOOT_HOLD_EN: adds boot_done and a reset-time BOOT state where the loader owns the port unlimited.
module mem_port_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int MIN_CPU   = 2
) (
  input  logic clk,
  input  logic rstb,
`ifdef MEM_ARB_BOOT_HOLD_EN
  input  logic boot_done,
`endif
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_CPU  = 2'd0,
    ST_DMA  = 2'd1,
    ST_SLOT = 2'd2
`ifdef MEM_ARB_BOOT_HOLD_EN
    , ST_BOOT = 2'd3
`endif
  } state_t;

  localparam logic [7:0] C_BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0] C_SLOT_LOAD  = 8'(MIN_CPU - 1);
`ifdef MEM_ARB_BOOT_HOLD_EN
  localparam state_t C_RST_STATE = ST_BOOT;
`else
  localparam state_t C_RST_STATE = ST_CPU;
`endif

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_burst_cnt;
  logic [7:0] w_burst_next;
  logic [7:0] r_slot_cnt;
  logic [7:0] w_slot_next;
  logic       w_dma_owner;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state     <= C_RST_STATE;
      r_burst_cnt <= 8'd0;
      r_slot_cnt  <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_burst_cnt <= w_burst_next;
      r_slot_cnt  <= w_slot_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_burst_next = r_burst_cnt;
    w_slot_next  = r_slot_cnt;
    case (r_state)
      ST_CPU: begin
        if (bus.dma_req) begin
          w_state_next = ST_DMA;
          w_burst_next = 8'd0;
        end
      end
      ST_DMA: begin
        // A dropped request costs one stalled idle cycle before the core gets the port back.
        if (!bus.dma_req) begin
          w_state_next = ST_CPU;
        end else if (r_burst_cnt == C_BURST_LAST) begin
          w_state_next = ST_SLOT;
          w_slot_next  = C_SLOT_LOAD;
        end else begin
          w_burst_next = r_burst_cnt + 8'd1;
        end
      end
      ST_SLOT: begin
        if (r_slot_cnt != 8'd0) begin
          w_slot_next = r_slot_cnt - 8'd1;
        end else if (bus.dma_req) begin
          w_state_next = ST_DMA;
          w_burst_next = 8'd0;
        end else begin
          w_state_next = ST_CPU;
        end
      end
`ifdef MEM_ARB_BOOT_HOLD_EN
      ST_BOOT: begin
        if (boot_done) begin
          w_state_next = ST_CPU;
        end
      end
`endif
      default: w_state_next = C_RST_STATE;
    endcase
  end

`ifdef MEM_ARB_BOOT_HOLD_EN
  assign w_dma_owner = (r_state == ST_DMA) || (r_state == ST_BOOT);
`else
  assign w_dma_owner = (r_state == ST_DMA);
`endif

  assign bus.cpu_stall   = w_dma_owner;
  assign bus.dma_gnt     = w_dma_owner;
  assign bus.dma_ack     = w_dma_owner & bus.dma_req;
  assign bus.cpu_rd_data = bus.mem_rd_data;
  assign bus.dma_rd_data = bus.mem_rd_data;
  assign bus.mem_addr    = w_dma_owner ? bus.dma_addr    : bus.cpu_addr;
  assign bus.mem_wr_data = w_dma_owner ? bus.dma_wr_data : bus.cpu_wr_data;
  // rstb gates the write strobe directly so nothing is written while reset is held.
  assign bus.mem_wr_ena  = rstb & (w_dma_owner ? (bus.dma_wr_ena & bus.dma_req) : bus.cpu_wr_ena);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with MAX_BURST=8, MIN_CPU=2 and a small behavioral memory.
// Status word checked per cycle: {cpu_stall, dma_gnt, dma_ack, mem_wr_ena}.
module tb_mem_port_arbiter;
  logic clk;
  logic rstb;
`ifdef MEM_ARB_BOOT_HOLD_EN
  logic boot_done;
`endif
  int n_vec;
  int n_err;
  logic [31:0] tb_mem [0:255];

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_BURST(8), .MIN_CPU(2)) dut (
    .clk      (clk),
    .rstb     (rstb),
`ifdef MEM_ARB_BOOT_HOLD_EN
    .boot_done(boot_done),
`endif
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rd_data = tb_mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (bus.mem_wr_ena === 1'b1) tb_mem[bus.mem_addr[9:2]] <= bus.mem_wr_data;
  end

  wire [3:0] w_sts = {bus.cpu_stall, bus.dma_gnt, bus.dma_ack, bus.mem_wr_ena};

  task automatic idle_inputs;
    bus.cpu_addr    = 32'h0;
    bus.cpu_wr_data = 32'h0;
    bus.cpu_wr_ena  = 1'b0;
    bus.dma_req     = 1'b0;
    bus.dma_addr    = 32'h0;
    bus.dma_wr_data = 32'h0;
    bus.dma_wr_ena  = 1'b0;
`ifdef MEM_ARB_BOOT_HOLD_EN
    boot_done       = 1'b0;
`endif
  endtask

  task automatic test_reset;
    logic [3:0]  exp_sts;
    logic [31:0] exp_addr;
    idle_inputs();
    rstb = 1'b0;
    bus.cpu_wr_ena = 1'b1;
    bus.cpu_addr   = 32'h40;
    bus.dma_req    = 1'b1;
    bus.dma_addr   = 32'h80;
    bus.dma_wr_ena = 1'b1;
    repeat (2) @(negedge clk);
    #1;
`ifdef MEM_ARB_BOOT_HOLD_EN
    exp_sts  = 4'b1110;
    exp_addr = 32'h80;
`else
    exp_sts  = 4'b0000;
    exp_addr = 32'h40;
`endif
    $display("reset: sts=%b mem_addr=%h", w_sts, bus.mem_addr);
    n_vec++;
    if (w_sts !== exp_sts) begin
      n_err++; $display("FAIL reset_sts: got %b want %b", w_sts, exp_sts);
    end
    n_vec++;
    if (bus.mem_addr !== exp_addr) begin
      n_err++; $display("FAIL reset_addr: got %h want %h", bus.mem_addr, exp_addr);
    end
    idle_inputs();
    rstb = 1'b1;
  endtask

`ifdef MEM_ARB_BOOT_HOLD_EN
  task automatic test_boot;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.dma_req     = 1'b1;
      bus.dma_wr_ena  = 1'b1;
      bus.dma_addr    = 32'h300 + 32'(4 * i);
      bus.dma_wr_data = 32'hB000_0000 + 32'(i);
      #1;
      $display("boot write %0d: sts=%b addr=%h", i, w_sts, bus.mem_addr);
      n_vec++;
      if (w_sts !== 4'b1111) begin
        n_err++; $display("FAIL boot_sts i=%0d: got %b want 1111", i, w_sts);
      end
    end
    @(negedge clk);
    idle_inputs();
    boot_done = 1'b1;
    #1;
    $display("boot_done: sts=%b", w_sts);
    n_vec++;
    if (w_sts !== 4'b1100) begin
      n_err++; $display("FAIL boot_done_cycle: got %b want 1100", w_sts);
    end
    @(negedge clk);
    boot_done    = 1'b0;
    bus.cpu_addr = 32'h34C;
    #1;
    $display("boot exit: sts=%b cpu_rd=%h", w_sts, bus.cpu_rd_data);
    n_vec++;
    if (w_sts !== 4'b0000) begin
      n_err++; $display("FAIL boot_exit_sts: got %b want 0000", w_sts);
    end
    n_vec++;
    if (bus.cpu_rd_data !== 32'hB000_0013) begin
      n_err++; $display("FAIL boot_readback: got %h want b0000013", bus.cpu_rd_data);
    end
  endtask
`endif

  task automatic test_idle_write;
    @(negedge clk);
    idle_inputs();
    bus.cpu_wr_ena  = 1'b1;
    bus.cpu_addr    = 32'h40;
    bus.cpu_wr_data = 32'h0000_1234;
    #1;
    $display("idle write: sts=%b addr=%h", w_sts, bus.mem_addr);
    n_vec++;
    if (w_sts !== 4'b0001) begin
      n_err++; $display("FAIL idle_write_sts: got %b want 0001", w_sts);
    end
    n_vec++;
    if (bus.mem_addr !== 32'h40 || bus.mem_wr_data !== 32'h1234) begin
      n_err++; $display("FAIL idle_write_bus: got %h/%h want 00000040/00001234", bus.mem_addr, bus.mem_wr_data);
    end
    @(negedge clk);
    bus.cpu_wr_ena = 1'b0;
    #1;
    $display("idle read: cpu_rd=%h", bus.cpu_rd_data);
    n_vec++;
    if (bus.cpu_rd_data !== 32'h1234) begin
      n_err++; $display("FAIL idle_readback: got %h want 00001234", bus.cpu_rd_data);
    end
  endtask

  task automatic test_simultaneous;
    @(negedge clk);
    idle_inputs();
    bus.cpu_wr_ena  = 1'b1;
    bus.cpu_addr    = 32'h44;
    bus.cpu_wr_data = 32'hCAFE_0001;
    bus.dma_req     = 1'b1;
    bus.dma_wr_ena  = 1'b1;
    bus.dma_addr    = 32'h48;
    bus.dma_wr_data = 32'h5555_AAAA;
    #1;
    $display("simul cpu cycle: sts=%b addr=%h", w_sts, bus.mem_addr);
    n_vec++;
    if (w_sts !== 4'b0001 || bus.mem_addr !== 32'h44) begin
      n_err++; $display("FAIL simul_cpu: got %b/%h want 0001/00000044", w_sts, bus.mem_addr);
    end
    @(negedge clk);
    #1;
    $display("simul dma cycle: sts=%b addr=%h", w_sts, bus.mem_addr);
    n_vec++;
    if (w_sts !== 4'b1111 || bus.mem_addr !== 32'h48 || bus.mem_wr_data !== 32'h5555_AAAA) begin
      n_err++; $display("FAIL simul_dma: got %b/%h/%h want 1111/00000048/5555aaaa", w_sts, bus.mem_addr, bus.mem_wr_data);
    end
    @(negedge clk);
    bus.dma_req = 1'b0;
    #1;
    $display("simul wasted: sts=%b", w_sts);
    n_vec++;
    if (w_sts !== 4'b1100) begin
      n_err++; $display("FAIL simul_wasted: got %b want 1100", w_sts);
    end
    @(negedge clk);
    idle_inputs();
    bus.cpu_addr = 32'h44;
    #1;
    $display("simul readback cpu: sts=%b rd=%h", w_sts, bus.cpu_rd_data);
    n_vec++;
    if (w_sts !== 4'b0000 || bus.cpu_rd_data !== 32'hCAFE_0001) begin
      n_err++; $display("FAIL simul_rd_cpu: got %b/%h want 0000/cafe0001", w_sts, bus.cpu_rd_data);
    end
    @(negedge clk);
    bus.cpu_addr = 32'h48;
    #1;
    $display("simul readback dma: rd=%h", bus.cpu_rd_data);
    n_vec++;
    if (bus.cpu_rd_data !== 32'h5555_AAAA) begin
      n_err++; $display("FAIL simul_rd_dma: got %h want 5555aaaa", bus.cpu_rd_data);
    end
  endtask

  task automatic test_dma_rw;
    @(negedge clk);
    idle_inputs();
    bus.dma_req     = 1'b1;
    bus.dma_wr_ena  = 1'b1;
    bus.dma_addr    = 32'h100;
    bus.dma_wr_data = 32'hDEAD_BEEF;
    #1;
    $display("dma_rw request: sts=%b", w_sts);
    n_vec++;
    if (w_sts !== 4'b0000) begin
      n_err++; $display("FAIL dma_rw_req: got %b want 0000", w_sts);
    end
    @(negedge clk);
    #1;
    $display("dma_rw write: sts=%b addr=%h data=%h", w_sts, bus.mem_addr, bus.mem_wr_data);
    n_vec++;
    if (w_sts !== 4'b1111 || bus.mem_addr !== 32'h100 || bus.mem_wr_data !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL dma_rw_write: got %b/%h/%h want 1111/00000100/deadbeef", w_sts, bus.mem_addr, bus.mem_wr_data);
    end
    @(negedge clk);
    bus.dma_wr_ena = 1'b0;
    #1;
    $display("dma_rw read: sts=%b rd=%h", w_sts, bus.dma_rd_data);
    n_vec++;
    if (w_sts !== 4'b1110 || bus.dma_rd_data !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL dma_rw_read: got %b/%h want 1110/deadbeef", w_sts, bus.dma_rd_data);
    end
    @(negedge clk);
    bus.dma_req    = 1'b0;
    bus.dma_wr_ena = 1'b1;
    #1;
    $display("dma_rw release: sts=%b", w_sts);
    n_vec++;
    if (w_sts !== 4'b1100) begin
      n_err++; $display("FAIL dma_rw_release: got %b want 1100", w_sts);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_sustained;
    logic [3:0] exp_sts;
    @(negedge clk);
    idle_inputs();
    bus.dma_req  = 1'b1;
    bus.dma_addr = 32'h200;
    #1;
    $display("sustained k=0: sts=%b", w_sts);
    n_vec++;
    if (w_sts !== 4'b0000) begin
      n_err++; $display("FAIL sustained k=0: got %b want 0000", w_sts);
    end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      bus.dma_addr = 32'h200 + 32'(4 * k);
      #1;
      exp_sts = (((k - 1) % 10) < 8) ? 4'b1110 : 4'b0000;
      $display("sustained k=%0d: sts=%b addr=%h", k, w_sts, bus.mem_addr);
      n_vec++;
      if (w_sts !== exp_sts) begin
        n_err++; $display("FAIL sustained k=%0d: got %b want %b", k, w_sts, exp_sts);
      end
    end
    @(negedge clk);
    bus.dma_req = 1'b0;
    #1;
    $display("sustained release: sts=%b", w_sts);
    n_vec++;
    if (w_sts !== 4'b1100) begin
      n_err++; $display("FAIL sustained_release: got %b want 1100", w_sts);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_drop;
    logic [3:0] exp_sts;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      bus.dma_req    = (c != 4 && c <= 14);
      bus.dma_wr_ena = (c == 4);
      bus.dma_addr   = 32'h280;
      #1;
      if (c == 4)                    exp_sts = 4'b1100;
      else if (c >= 1 && c <= 3)     exp_sts = 4'b1110;
      else if (c >= 6 && c <= 13)    exp_sts = 4'b1110;
      else                           exp_sts = 4'b0000;
      $display("drop c=%0d: sts=%b", c, w_sts);
      n_vec++;
      if (w_sts !== exp_sts) begin
        n_err++; $display("FAIL drop c=%0d: got %b want %b", c, w_sts, exp_sts);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midburst;
    logic [3:0] exp_sts;
`ifdef MEM_ARB_BOOT_HOLD_EN
    localparam int LAST = 9;
`else
    localparam int LAST = 8;
`endif
    for (int c = 0; c <= LAST; c++) begin
      @(negedge clk);
      bus.dma_wr_ena  = 1'b1;
      bus.dma_addr    = 32'h2C0 + 32'(4 * c);
      bus.dma_wr_data = 32'h7700_0000 + 32'(c);
      rstb            = (c != 4);
`ifdef MEM_ARB_BOOT_HOLD_EN
      bus.dma_req = (c <= 4) || (c == 6) || (c == 7);
      boot_done   = (c == 5);
      if (c == 0)                 exp_sts = 4'b0000;
      else if (c <= 3)            exp_sts = 4'b1111;
      else if (c == 4)            exp_sts = 4'b1110;
      else if (c == 5 || c == 8)  exp_sts = 4'b1100;
      else if (c == 7)            exp_sts = 4'b1111;
      else                        exp_sts = 4'b0000;
`else
      bus.dma_req = (c <= 6);
      if (c == 0)                 exp_sts = 4'b0000;
      else if (c <= 3)            exp_sts = 4'b1111;
      else if (c == 4)            exp_sts = 4'b1110;
      else if (c == 6)            exp_sts = 4'b1111;
      else if (c == 7)            exp_sts = 4'b1100;
      else                        exp_sts = 4'b0000;
`endif
      #1;
      $display("rst_midburst c=%0d: rstb=%b sts=%b", c, rstb, w_sts);
      n_vec++;
      if (w_sts !== exp_sts) begin
        n_err++; $display("FAIL rst_midburst c=%0d: got %b want %b", c, w_sts, exp_sts);
      end
    end
    rstb = 1'b1;
    idle_inputs();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
    test_reset();
`ifdef MEM_ARB_BOOT_HOLD_EN
    test_boot();
`endif
    test_idle_write();
    test_simultaneous();
    test_dma_rw();
    test_sustained();
    test_drop();
    test_reset_midburst();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
